inst_fetch_queue: RTL and testbench
===================================

INST_FETCH_QUEUE -- requirements
Module: inst_fetch_queue

Interface
REQ-001 SHALL have parameter DATA_W, default 16, meaning instruction width in bits.
REQ-002 SHALL have parameter ADDR_W, default 16, meaning PC width in bits (byte address).
REQ-003 SHALL have parameter DEPTH, default 256, meaning instruction words in internal memory.
REQ-004 SHALL have parameter QDEPTH, default 4 (power of 2, >=2), meaning output queue entries.
REQ-005 SHALL have parameter RESET_PC, default 0, meaning first fetch address after reset.
REQ-006 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-007 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-008 SHALL have port prog_we  input  1  memory write enable.
REQ-009 SHALL have port prog_addr  input  ADDR_W  write byte address; bit 0 ignored.
REQ-010 SHALL have port prog_data  input  DATA_W  write data.
REQ-011 SHALL have port redirect  input  1  branch/jump: flush and restart fetch.
REQ-012 SHALL have port redirect_pc  input  ADDR_W  restart byte address.
REQ-013 SHALL have port inst_ready  input  1  consumer accepts head entry.
REQ-014 SHALL have port inst_valid  output  1  queue head holds a valid instruction.
REQ-015 SHALL have port inst_out  output  DATA_W  head instruction.
REQ-016 SHALL have port inst_pc  output  ADDR_W  byte address of head instruction.
REQ-017 SHALL have port inst_err  output  1  head fetched from out-of-range address.

Function
REQ-018 Memory SHALL be word-addressed, index = pc[ADDR_W-1:1]; pc[0] ignored on all addresses.
REQ-019 Memory read SHALL be registered: read issued at edge t is pushed into queue at edge t+1.
REQ-020 Fetch SHALL issue at an edge when (count + rd_pending) < QDEPTH, using pre-edge values; pops in the same cycle are not credited.
REQ-021 Each issue SHALL capture mem data, the fetch PC and range flag, set rd_pending, and advance fetch_pc by 2 modulo 2^ADDR_W.
REQ-022 Index >= DEPTH SHALL return data 0 with inst_err=1 for that entry; fetch continues.
REQ-023 inst_valid SHALL equal (count != 0); inst_out/inst_pc/inst_err SHALL reflect the head entry combinationally.
REQ-024 Pop SHALL occur on an edge where inst_valid && inst_ready; push and pop in the same edge SHALL leave count unchanged.
REQ-025 Queue SHALL never overflow; data SHALL leave in fetch order with no loss or duplication under any inst_ready pattern.
REQ-026 redirect SHALL have priority over push, pop and issue: count<=0, rd_pending<=0, fetch_pc<={redirect_pc[ADDR_W-1:1],1'b0}; a pop handshake in that cycle is discarded.
REQ-027 First instruction after redirect or reset SHALL be valid 2 edges later; steady-state throughput with inst_ready=1 SHALL be 1 instruction/cycle.
REQ-028 prog_we SHALL write mem at the next edge; a same-edge read of that address SHALL return the old data.
REQ-029 Writes to index >= DEPTH SHALL be ignored.
REQ-030 Writes SHALL NOT flush queue entries already fetched.

Reset
REQ-031 rst SHALL set count=0, rd_pending=0, fetch_pc=RESET_PC with bit 0 cleared, queue pointers 0; inst_valid=0, inst_out=0, inst_pc=0, inst_err=0 while empty.
REQ-032 rst SHALL take priority over redirect, prog_we and all handshakes.
REQ-033 Memory contents SHALL be unaffected by rst.
REQ-034 rst mid-operation SHALL discard all queued and in-flight entries.

Verification
REQ-035 Preload words 0..6 = 16'h1000..16'h1006, release rst, inst_ready=1 -> edge 2: inst_pc=0x0000, inst_out=16'h1000; then 0x0002/16'h1001 each cycle, no bubbles.
REQ-036 inst_ready=0 for 10 cycles after reset -> count saturates at 4 (pcs 0x0000..0x0006), fetch_pc=0x0008; raise ready -> 0x0000,0x0002,... in order, none lost.
REQ-037 Queue full, redirect=1 with redirect_pc=0x0007, inst_ready=1 -> head 0x0000 not consumed; inst_valid=0 next cycle; 2 edges later inst_pc=0x0006, inst_out=16'h1003.
REQ-038 DEPTH=256, redirect_pc=0x01FE -> inst_pc 0x01FE inst_err=0, then 0x0200 with inst_out=0, inst_err=1.
REQ-039 prog_we to 0x0004 data 16'hBEEF on the edge that fetches 0x0004 -> delivered 16'h1002; refetch via redirect to 0x0004 -> 16'hBEEF.
REQ-040 rst asserted with 3 entries queued and a read pending -> next cycle inst_valid=0; after release first inst_pc=RESET_PC.

Source files
------------

// File: rtl/inst_fetch_queue.sv
// inst_fetch_queue: word-addressed instruction memory feeding a small in-order fetch queue with redirect.
module inst_fetch_queue #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 16,
  parameter int DEPTH = 256,
  parameter int QDEPTH = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              prog_we,
  input  logic [ADDR_W-1:0] prog_addr,
  input  logic [DATA_W-1:0] prog_data,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirect_pc,
  input  logic              inst_ready,
  output logic              inst_valid,
  output logic [DATA_W-1:0] inst_out,
  output logic [ADDR_W-1:0] inst_pc,
  output logic              inst_err
);
  localparam int MW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  localparam int QW = $clog2(QDEPTH);
  localparam int unsigned DEPTH_U = DEPTH;
  localparam int unsigned QDEPTH_U = QDEPTH;
  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] q_data [QDEPTH];
  logic [ADDR_W-1:0] q_pc [QDEPTH];
  logic [QDEPTH-1:0] q_err;
  logic [QW-1:0] wr_ptr, rd_ptr;
  logic [QW:0] count;
  logic rd_pending, rd_err;
  logic [DATA_W-1:0] rd_data;
  logic [ADDR_W-1:0] rd_pc, fetch_pc;
  logic fetch_ok, prog_ok, issue, pop;
  logic unused;
  assign unused = &{1'b0, prog_addr[0], redirect_pc[0]};
  assign fetch_ok = 32'(fetch_pc[ADDR_W-1:1]) < DEPTH_U;
  assign prog_ok = 32'(prog_addr[ADDR_W-1:1]) < DEPTH_U;
  // pops in the same cycle are deliberately not credited, keeping issue off the consumer path
  assign issue = 32'(count) + 32'(rd_pending) < QDEPTH_U;
  assign pop = inst_valid && inst_ready;
  assign inst_valid = count != '0;
  assign inst_out = inst_valid ? q_data[rd_ptr] : '0;
  assign inst_pc = inst_valid ? q_pc[rd_ptr] : '0;
  assign inst_err = inst_valid && q_err[rd_ptr];
  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
      rd_pending <= 1'b0;
      fetch_pc <= {RESET_PC[ADDR_W-1:1], 1'b0};
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (redirect) begin
      count <= '0;
      rd_pending <= 1'b0;
      fetch_pc <= {redirect_pc[ADDR_W-1:1], 1'b0};
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      rd_pending <= issue;
      if (issue) fetch_pc <= fetch_pc + ADDR_W'(2);
      if (rd_pending) wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      count <= count + (QW+1)'(rd_pending) - (QW+1)'(pop);
    end
  end
  always_ff @(posedge clk) begin
    if (issue) begin
      rd_data <= fetch_ok ? mem[fetch_pc[MW:1]] : '0;
      rd_pc <= fetch_pc;
      rd_err <= !fetch_ok;
    end
    if (rd_pending) begin
      q_data[wr_ptr] <= rd_data;
      q_pc[wr_ptr] <= rd_pc;
      q_err[wr_ptr] <= rd_err;
    end
    if (prog_we && prog_ok) mem[prog_addr[MW:1]] <= prog_data;
  end
endmodule

// File: tb/tb_inst_fetch_queue.sv
// tb_inst_fetch_queue: directed stimulus, queue-level reference model checked every cycle plus literal pins.
module tb_inst_fetch_queue;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic prog_we = 1'b0;
  logic [15:0] prog_addr = '0;
  logic [15:0] prog_data = '0;
  logic redirect = 1'b0;
  logic [15:0] redirect_pc = '0;
  logic inst_ready = 1'b0;
  logic inst_valid;
  logic [15:0] inst_out;
  logic [15:0] inst_pc;
  logic inst_err;
  int checks = 0;
  int failures = 0;
  bit armed = 1'b0;

  inst_fetch_queue #(.DATA_W(16), .ADDR_W(16), .DEPTH(256), .QDEPTH(4), .RESET_PC(16'h0000)) dut (
    .clk(clk), .rst(rst), .prog_we(prog_we), .prog_addr(prog_addr), .prog_data(prog_data),
    .redirect(redirect), .redirect_pc(redirect_pc), .inst_ready(inst_ready),
    .inst_valid(inst_valid), .inst_out(inst_out), .inst_pc(inst_pc), .inst_err(inst_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] d;
    logic [15:0] pc;
    logic e;
  } ent_t;

  ent_t mq[$];
  ent_t pe;
  bit pend = 1'b0;
  bit iss;
  logic [15:0] fpc = '0;
  logic [15:0] mmem [256];

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", nm, got, exp);
    end
  endtask

  always @(posedge clk) begin
    if (rst) begin
      mq.delete();
      pend = 1'b0;
      fpc = 16'h0000;
    end else if (redirect) begin
      mq.delete();
      pend = 1'b0;
      fpc = {redirect_pc[15:1], 1'b0};
    end else begin
      iss = (mq.size() + int'(pend)) < 4;
      if (inst_ready && mq.size() > 0) void'(mq.pop_front());
      if (pend) mq.push_back(pe);
      if (iss) begin
        pe.pc = fpc;
        pe.e = fpc[15:1] >= 15'd256;
        pe.d = pe.e ? 16'h0 : mmem[fpc[8:1]];
        fpc = fpc + 16'd2;
      end
      pend = iss;
    end
    if (prog_we && prog_addr[15:1] < 15'd256) mmem[prog_addr[8:1]] = prog_data;
  end

  always @(negedge clk) begin
    if (armed) begin
      chk("model_valid", 32'(inst_valid), 32'(mq.size() != 0));
      chk("model_out", 32'(inst_out), mq.size() != 0 ? 32'(mq[0].d) : 32'h0);
      chk("model_pc", 32'(inst_pc), mq.size() != 0 ? 32'(mq[0].pc) : 32'h0);
      chk("model_err", 32'(inst_err), mq.size() != 0 ? 32'(mq[0].e) : 32'h0);
    end
  end

  initial begin
    for (int i = 0; i < 256; i++) begin
      @(negedge clk);
      armed = 1'b1;
      prog_we = 1'b1;
      prog_addr = 16'(2 * i);
      prog_data = 16'(16'h1000 + i);
    end
    @(negedge clk);
    prog_we = 1'b0;
    @(negedge clk);
    chk("rst_valid", 32'(inst_valid), 0);
    chk("rst_out", 32'(inst_out), 0);
    chk("rst_pc", 32'(inst_pc), 0);
    chk("rst_err", 32'(inst_err), 0);
    rst = 1'b0;
    inst_ready = 1'b1;
    @(negedge clk);
    chk("first_e1_valid", 32'(inst_valid), 0);
    @(negedge clk);
    chk("first_pc", 32'(inst_pc), 32'h0000);
    chk("first_out", 32'(inst_out), 32'h1000);
    for (int k = 1; k < 6; k++) begin
      @(negedge clk);
      chk("stream_pc", 32'(inst_pc), 32'(2 * k));
      chk("stream_out", 32'(inst_out), 32'(16'h1000 + k));
    end
    rst = 1'b1;
    inst_ready = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    repeat (10) @(negedge clk);
    chk("sat_valid", 32'(inst_valid), 1);
    chk("sat_pc", 32'(inst_pc), 32'h0000);
    chk("sat_count", 32'(dut.count), 4);
    chk("sat_fetch_pc", 32'(dut.fetch_pc), 32'h0008);
    inst_ready = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      chk("drain_pc", 32'(inst_pc), 32'(2 * k));
    end
    rst = 1'b1;
    inst_ready = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    repeat (6) @(negedge clk);
    chk("full_count", 32'(dut.count), 4);
    redirect = 1'b1;
    redirect_pc = 16'h0007;
    inst_ready = 1'b1;
    @(negedge clk);
    redirect = 1'b0;
    chk("redir_valid0", 32'(inst_valid), 0);
    @(negedge clk);
    chk("redir_valid1", 32'(inst_valid), 0);
    @(negedge clk);
    chk("redir_pc", 32'(inst_pc), 32'h0006);
    chk("redir_out", 32'(inst_out), 32'h1003);
    redirect = 1'b1;
    redirect_pc = 16'h01FE;
    @(negedge clk);
    redirect = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("edge_pc", 32'(inst_pc), 32'h01FE);
    chk("edge_err", 32'(inst_err), 0);
    chk("edge_out", 32'(inst_out), 32'h10FF);
    @(negedge clk);
    chk("oor_pc", 32'(inst_pc), 32'h0200);
    chk("oor_out", 32'(inst_out), 0);
    chk("oor_err", 32'(inst_err), 1);
    redirect = 1'b1;
    redirect_pc = 16'h0000;
    @(negedge clk);
    redirect = 1'b0;
    @(negedge clk);
    @(negedge clk);
    prog_we = 1'b1;
    prog_addr = 16'h0004;
    prog_data = 16'hBEEF;
    @(negedge clk);
    prog_we = 1'b0;
    chk("wr_pc2", 32'(inst_pc), 32'h0002);
    @(negedge clk);
    chk("wr_old_pc", 32'(inst_pc), 32'h0004);
    chk("wr_old_out", 32'(inst_out), 32'h1002);
    redirect = 1'b1;
    redirect_pc = 16'h0004;
    @(negedge clk);
    redirect = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("wr_new_pc", 32'(inst_pc), 32'h0004);
    chk("wr_new_out", 32'(inst_out), 32'hBEEF);
    for (int k = 0; k < 30; k++) begin
      inst_ready = (k % 3) != 0;
      @(negedge clk);
    end
    inst_ready = 1'b0;
    redirect = 1'b1;
    redirect_pc = 16'h0000;
    @(negedge clk);
    redirect = 1'b0;
    repeat (4) @(negedge clk);
    chk("pre_rst_count", 32'(dut.count), 3);
    chk("pre_rst_pending", 32'(dut.rd_pending), 1);
    rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_valid", 32'(inst_valid), 0);
    rst = 1'b0;
    inst_ready = 1'b1;
    @(negedge clk);
    chk("post_rst_valid", 32'(inst_valid), 0);
    @(negedge clk);
    chk("post_rst_valid2", 32'(inst_valid), 1);
    chk("post_rst_pc", 32'(inst_pc), 32'h0000);
    repeat (2) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
